// File: rtl/sap1_pkg.sv
// Types and RAM geometry shared between the SAP-1 program loader and the CPU-side RAM.
package sap1_pkg;

  localparam int RAM_PROFUNDIDADE     = 32;
  localparam int RAM_LARGURA_DADO     = 8;
  localparam int RAM_LARGURA_ENDERECO = 5;

  typedef enum logic [2:0] {
    OCIOSO,
    CARGA,
    CHECKSUM,
    LIBERA,
    EXECUTA
  } estado_carregador_t;

endpackage

// File: rtl/carregador_programa.sv
// SAP-1 program loader: streams a length-prefixed program into RAM, verifies a trailing
// checksum and keeps the CPU in reset until a clean load has completed.
module carregador_programa
  import sap1_pkg::*;
#(
  parameter int LARGURA_ENDERECO = RAM_LARGURA_ENDERECO,
  parameter int LARGURA_DADO     = RAM_LARGURA_DADO
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        iniciar,
  input  logic [LARGURA_ENDERECO:0]   comprimento,
  input  logic [LARGURA_DADO-1:0]     dado_entrada,
  input  logic                        dado_valido,
  output logic                        dado_pronto,
  output logic                        ram_we,
  output logic [LARGURA_ENDERECO-1:0] ram_endereco,
  output logic [LARGURA_DADO-1:0]     ram_dado,
  output logic                        cpu_reset,
  output logic                        ocupado,
  output logic                        concluido,
  output logic                        erro_checksum,
  output estado_carregador_t          estado
);

  localparam int                 LC         = LARGURA_ENDERECO + 1;
  localparam logic [LC-1:0]      COMP_MAX   = LC'(2 ** LARGURA_ENDERECO);

  // Handshake: a byte moves on every rising edge where dado_valido && dado_pronto.
  // dado_pronto is decoded from state alone, never from dado_valido.

  estado_carregador_t            r_estado, w_estado_prox;
  logic [LC-1:0]                 r_comprimento, w_comprimento_prox;
  logic [LC-1:0]                 r_idx, w_idx_prox;
  logic [LARGURA_DADO-1:0]       r_soma, w_soma_prox;
  logic                          r_concluido, w_concluido_prox;
  logic                          r_erro, w_erro_prox;
  logic                          r_ram_we, w_ram_we_prox;
  logic [LARGURA_ENDERECO-1:0]   r_ram_endereco, w_ram_endereco_prox;
  logic [LARGURA_DADO-1:0]       r_ram_dado, w_ram_dado_prox;
  logic                          r_cpu_reset;

  logic                          w_pronto;
  logic                          w_transf;
  logic                          w_inicio_ok;
  logic [LC-1:0]                 w_idx_inc;
  logic [LARGURA_DADO-1:0]       w_soma_ck;

  assign w_pronto    = (r_estado == CARGA) || (r_estado == CHECKSUM);
  assign w_transf    = dado_valido && w_pronto;
  assign w_inicio_ok = iniciar && ((r_estado == OCIOSO) || (r_estado == EXECUTA)) &&
                       (comprimento != '0) && (comprimento <= COMP_MAX);
  assign w_idx_inc   = r_idx + LC'(1);
  assign w_soma_ck   = r_soma + dado_entrada;

  always_comb begin
    w_estado_prox       = r_estado;
    w_comprimento_prox  = r_comprimento;
    w_idx_prox          = r_idx;
    w_soma_prox         = r_soma;
    w_concluido_prox    = r_concluido;
    w_erro_prox         = r_erro;
    w_ram_we_prox       = 1'b0;
    w_ram_endereco_prox = r_ram_endereco;
    w_ram_dado_prox     = r_ram_dado;

    case (r_estado)
      OCIOSO, EXECUTA: begin
        if (w_inicio_ok) begin
          w_comprimento_prox = comprimento;
          w_idx_prox         = '0;
          w_soma_prox        = '0;
          w_concluido_prox   = 1'b0;
          w_erro_prox        = 1'b0;
          w_estado_prox      = CARGA;
        end
      end
      CARGA: begin
        if (w_transf) begin
          w_ram_we_prox       = 1'b1;
          w_ram_endereco_prox = r_idx[LARGURA_ENDERECO-1:0];
          w_ram_dado_prox     = dado_entrada;
          w_soma_prox         = w_soma_ck;
          w_idx_prox          = w_idx_inc;
          // idx stops at comprimento, so the address never wraps past the last word.
          if (w_idx_inc == r_comprimento) w_estado_prox = CHECKSUM;
        end
      end
      CHECKSUM: begin
        if (w_transf) begin
          if (w_soma_ck == '0) begin
            w_concluido_prox = 1'b1;
            w_estado_prox    = LIBERA;
          end else begin
            w_erro_prox   = 1'b1;
            w_estado_prox = OCIOSO;
          end
        end
      end
      LIBERA:  w_estado_prox = EXECUTA;
      default: w_estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado       <= OCIOSO;
      r_comprimento  <= '0;
      r_idx          <= '0;
      r_soma         <= '0;
      r_concluido    <= 1'b0;
      r_erro         <= 1'b0;
      r_ram_we       <= 1'b0;
      r_ram_endereco <= '0;
      r_ram_dado     <= '0;
      r_cpu_reset    <= 1'b1;
    end else begin
      r_estado       <= w_estado_prox;
      r_comprimento  <= w_comprimento_prox;
      r_idx          <= w_idx_prox;
      r_soma         <= w_soma_prox;
      r_concluido    <= w_concluido_prox;
      r_erro         <= w_erro_prox;
      r_ram_we       <= w_ram_we_prox;
      r_ram_endereco <= w_ram_endereco_prox;
      r_ram_dado     <= w_ram_dado_prox;
      // Registered so the CPU reset is glitch-free; it drops only while in EXECUTA.
      r_cpu_reset    <= (w_estado_prox != EXECUTA);
    end
  end

  assign dado_pronto   = w_pronto;
  assign ram_we        = r_ram_we;
  assign ram_endereco  = r_ram_endereco;
  assign ram_dado      = r_ram_dado;
  assign cpu_reset     = r_cpu_reset;
  assign ocupado       = (r_estado == CARGA) || (r_estado == CHECKSUM) || (r_estado == LIBERA);
  assign concluido     = r_concluido;
  assign erro_checksum = r_erro;
  assign estado        = r_estado;

endmodule

// File: tb/tb_carregador_programa.sv
// Directed and randomized bench for the SAP-1 program loader against a byte-stream/RAM model.
module tb_carregador_programa;
  import sap1_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               iniciar;
  logic [5:0]         comprimento;
  logic [7:0]         dado_entrada;
  logic               dado_valido;
  logic               dado_pronto;
  logic               ram_we;
  logic [4:0]         ram_endereco;
  logic [7:0]         ram_dado;
  logic               cpu_reset;
  logic               ocupado;
  logic               concluido;
  logic               erro_checksum;
  estado_carregador_t estado;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];
  int          got_cyc[$];
  logic [7:0]  pay[32];

  carregador_programa dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .comprimento(comprimento),
    .dado_entrada(dado_entrada), .dado_valido(dado_valido), .dado_pronto(dado_pronto),
    .ram_we(ram_we), .ram_endereco(ram_endereco), .ram_dado(ram_dado),
    .cpu_reset(cpu_reset), .ocupado(ocupado), .concluido(concluido),
    .erro_checksum(erro_checksum), .estado(estado)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // RAM-port monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (ram_we) begin
      got_q.push_back({ram_endereco, ram_dado});
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"}, cpu_reset, 1);
    check({tag, "_pronto"}, dado_pronto, 0);
    check({tag, "_we"}, ram_we, 0);
    check({tag, "_end"}, ram_endereco, 0);
    check({tag, "_dado"}, ram_dado, 0);
    check({tag, "_ocupado"}, ocupado, 0);
    check({tag, "_concluido"}, concluido, 0);
    check({tag, "_erro"}, erro_checksum, 0);
    check({tag, "_estado"}, estado, OCIOSO);
  endtask

  task automatic start(input logic [5:0] len);
    iniciar     = 1'b1;
    comprimento = len;
    tick();
    iniciar     = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int budget;
    if (gap) begin
      dado_valido = 1'b0;
      tick();
    end
    dado_valido  = 1'b1;
    dado_entrada = b;
    budget = 0;
    while (!dado_pronto && budget < 20) begin
      tick();
      budget++;
    end
    if (!dado_pronto) check("pronto_timeout", dado_pronto, 1);
    tick();
  endtask

  // gapmode: 0 valid held high, 1 valid toggled every other cycle, 2 random gaps.
  // inj: pulse a (should-be-ignored) iniciar while the second payload byte transfers.
  task automatic run_load(input int len, input logic [7:0] ck, input int gapmode, input bit inj);
    int  s;
    bit  pass;
    bit  gap;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    s = 0;
    start(6'(len));
    check("start_pronto", dado_pronto, 1);
    check("start_estado", estado, CARGA);
    check("start_cpu_reset", cpu_reset, 1);
    check("start_flags", {concluido, erro_checksum}, 0);
    for (int i = 0; i < len; i++) begin
      s += pay[i];
      exp_q.push_back({5'(i), pay[i]});
      gap = (gapmode == 1) ? 1'b1 : (gapmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (inj && i == 1) begin
        iniciar     = 1'b1;
        comprimento = 6'd5;
      end
      send(pay[i], gap);
      iniciar = 1'b0;
    end
    gap = (gapmode == 1) ? 1'b1 : (gapmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    send(ck, gap);
    dado_valido = 1'b0;
    pass = (((s + int'(ck)) % 256) == 0);
    check("ck_concluido", concluido, pass);
    check("ck_erro", erro_checksum, !pass);
    check("ck_estado", estado, pass ? LIBERA : OCIOSO);
    check("ck_cpu_reset", cpu_reset, 1);
    check("n_writes", got_q.size(), len);
    for (int i = 0; i < len && i < got_q.size(); i++)
      check($sformatf("write_%0d", i), got_q[i], exp_q[i]);
    if (gapmode < 2)
      for (int i = 1; i < len && i < got_cyc.size(); i++)
        check($sformatf("write_gap_%0d", i), got_cyc[i] - got_cyc[i-1], gapmode + 1);
    tick();
    check("after_cpu_reset", cpu_reset, !pass);
    check("after_estado", estado, pass ? EXECUTA : OCIOSO);
    check("after_we", ram_we, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int  len;
    int  s;
    bit  good;
    reset        = 1'b1;
    iniciar      = 1'b0;
    comprimento  = '0;
    dado_entrada = '0;
    dado_valido  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_vals("rst");

    // Out-of-range lengths are ignored in OCIOSO
    start(6'd0);
    check("len0_idle_estado", estado, OCIOSO);
    check("len0_idle_pronto", dado_pronto, 0);
    start(6'd33);
    check("len33_idle_estado", estado, OCIOSO);
    check("len33_idle_ocupado", ocupado, 0);

    // Basic load
    pay[0] = 8'h09; pay[1] = 8'h1A; pay[2] = 8'hE0;
    run_load(3, 8'hFD, 0, 1'b0);
    check("basic_concluido_hold", concluido, 1);

    // Out-of-range lengths are ignored in EXECUTA
    start(6'd0);
    check("len0_exec_estado", estado, EXECUTA);
    check("len0_exec_cpu_reset", cpu_reset, 0);
    start(6'd33);
    check("len33_exec_estado", estado, EXECUTA);
    check("len33_exec_concluido", concluido, 1);

    // Bad checksum, launched from EXECUTA (cpu_reset must rise at once)
    run_load(3, 8'hFE, 0, 1'b0);
    tick();
    check("bad_cpu_reset_stays", cpu_reset, 1);
    check("bad_erro_sticky", erro_checksum, 1);

    // Full memory, gapped handshake
    s = 0;
    for (int i = 0; i < 32; i++) begin
      pay[i] = 8'($urandom);
      s += pay[i];
    end
    run_load(32, 8'((256 - (s % 256)) % 256), 1, 1'b0);

    // iniciar during CARGA is ignored
    s = 0;
    for (int i = 0; i < 3; i++) begin
      pay[i] = 8'($urandom);
      s += pay[i];
    end
    run_load(3, 8'((256 - (s % 256)) % 256), 0, 1'b1);

    // Random loads
    for (int k = 0; k < 6; k++) begin
      len  = $urandom_range(1, 32);
      good = 1'($urandom_range(0, 1));
      s = 0;
      for (int i = 0; i < len; i++) begin
        pay[i] = 8'($urandom);
        s += pay[i];
      end
      run_load(len, 8'((256 - (s % 256) + (good ? 0 : $urandom_range(1, 255))) % 256), 2, 1'b0);
    end

    // Mid-load reset after two payload bytes
    got_q.delete();
    got_cyc.delete();
    start(6'd4);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    reset        = 1'b1;
    dado_valido  = 1'b1;
    dado_entrada = 8'h33;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0;
    tick();
    tick();
    tick();
    dado_valido = 1'b0;
    check("midrst_n_writes", got_q.size(), 2);
    check("midrst_estado_after", estado, OCIOSO);
    check("midrst_cpu_reset_after", cpu_reset, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/carregador_programa.md
# carregador_programa

Program loader for the SAP-1 memory: the writer side of the RAM that the CPU fetches from. It accepts a length-prefixed byte stream over a valid/ready handshake, writes the bytes into consecutive RAM addresses from 0 and checks a trailing checksum. It holds the CPU in reset during loading and releases it only after a clean load. It sits between the external programming interface and the CPU's RAM write port and reset input.

## Interface
- LARGURA_ENDERECO, 5, RAM address width (32 words)
- LARGURA_DADO, 8, RAM word width
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- iniciar  in  1  one-cycle start request
- comprimento  in  6  payload word count, valid range 1..32; sampled with iniciar
- dado_entrada  in  8  stream byte
- dado_valido  in  1  source has a byte on dado_entrada
- dado_pronto  out  1  loader accepts a byte this cycle
- ram_we  out  1  RAM write strobe, registered
- ram_endereco  out  5  RAM write address, registered
- ram_dado  out  8  RAM write data, registered
- cpu_reset  out  1  reset to the CPU, active-high
- ocupado  out  1  high in CARGA, CHECKSUM and LIBERA
- concluido  out  1  sticky; last load succeeded
- erro_checksum  out  1  sticky; last load failed the checksum

## Operation
- Handshake: a byte transfers in any cycle where dado_valido && dado_pronto. dado_valido may stay high; dado_pronto depends only on state.
- States:
  - OCIOSO: reset state. cpu_reset=1, dado_pronto=0.
  - CARGA: dado_pronto=1. Each transfer writes the byte to address idx, then idx++. Goes to CHECKSUM after transfer number comprimento.
  - CHECKSUM: dado_pronto=1. On transfer, if (sum of payload + byte) mod 256 == 0, go to LIBERA. Otherwise set erro_checksum=1 and go to OCIOSO.
  - LIBERA: one cycle. cpu_reset=1, concluido set.
  - EXECUTA: cpu_reset=0, dado_pronto=0.
- iniciar is accepted only in OCIOSO or EXECUTA, and only if 1 ≤ comprimento ≤ 32. On accept:
  - latch comprimento
  - idx=0, sum=0
  - clear concluido and erro_checksum
  - go to CARGA
- iniciar is ignored in CARGA, CHECKSUM and LIBERA, and ignored when comprimento is out of range.
- Accepting iniciar in EXECUTA re-asserts cpu_reset from the next cycle, so the CPU is halted before the first new write.
- Checksum arithmetic is an 8-bit wrap-around sum. Payload bytes are never discarded on a checksum failure; RAM holds the data but the CPU is not released.
- Address never wraps. With comprimento=32, idx ends at 31 and the next transfer is the checksum.

## Timing
- Reset values:
  - cpu_reset=1
  - dado_pronto=0, ram_we=0, ram_endereco=0, ram_dado=0
  - ocupado=0, concluido=0, erro_checksum=0
  - state OCIOSO
- iniciar at cycle t: dado_pronto=1 at t+1.
- Transfer at cycle k: ram_we=1 with ram_endereco/ram_dado valid at k+1, for exactly one cycle.
- Checksum transfer at cycle c:
  - pass: LIBERA at c+1, concluido=1 at c+1, cpu_reset=0 from c+2.
  - fail: erro_checksum=1 and OCIOSO at c+1.
- The last RAM write always completes at or before c, so the CPU never fetches before its last word is written.
- reset mid-load takes effect at the next edge:
  - state returns to OCIOSO
  - any pending ram_we is dropped
  - flags are cleared
  - cpu_reset goes to 1

## Structure
- Package sap1_pkg holds:
  - enum estado_carregador_t {OCIOSO, CARGA, CHECKSUM, LIBERA, EXECUTA}
  - constants for RAM depth (32) and data width (8)
- These are shared with the CPU-side RAM.
- Single module; no sub-module is warranted. It consists of the FSM, the idx counter, the sum accumulator and the output registers.

## Test plan
- **Basic load:** iniciar with comprimento=3; stream 0x09,0x1A,0xE0 then checksum 0xFD, dado_valido held high.
  - Required: writes 0→0x09, 1→0x1A, 2→0xE0 on consecutive cycles; concluido=1; cpu_reset falls 2 cycles after the checksum transfer.
- **Bad checksum:** same stream with checksum 0xFE.
  - Required: erro_checksum=1, concluido=0, cpu_reset stays 1, state OCIOSO.
- **Gapped handshake and full memory:** comprimento=32, dado_valido toggled every other cycle.
  - Required: exactly 32 writes, addresses 0..31, no write in idle cycles, no wrap to 0.
- **Ignored requests:**
  - iniciar with comprimento=0 or 33 → nothing changes.
  - iniciar during CARGA → ignored and the load continues.
- **Reload and mid-load reset:**
  - iniciar in EXECUTA → cpu_reset=1 the next cycle.
  - reset after 2 payload bytes → all outputs at reset values, and no further ram_we.
